morse_pattern_shifter: RTL and testbench
========================================

# morse_pattern_shifter

- Consumes the one-cycle enable tick from the rate divider stage (the `RateDividerCounter == 0` pulse) and serialises a Morse-code pattern onto a single LED, one pattern bit per tick.
- A 3-bit letter code selects one of eight letters (S–Z).
- A start request latches the letter, and the block shifts out on/off units until the pattern ends, then reports done.
- Sits directly downstream of the rate divider, in place of (or alongside) the 4-bit display counter.

## Interface
Parameters:
- PAT_W, 14, width of pattern shift register (longest pattern, Y)
- LEN_W, 4, width of remaining-bit counter

Ports:
- ClockIn  input  1  system clock; all state on rising edge
- Clear_b  input  1  reset, asynchronous, active-low
- Tick  input  1  one-cycle enable pulse from rate divider; one Morse unit per Tick
- Start  input  1  transmission request, rising-edge detected (level-repeat under macro, see Configuration)
- Letter  input  3  letter select: 0=S 1=T 2=U 3=V 4=W 5=X 6=Y 7=Z; sampled only on accepted Start
- LedOut  output  1  registered Morse output, 1 = LED on
- Busy  output  1  high from accepted Start through the final Tick
- Done  output  1  one-cycle pulse on completion

## Operation
- Encoding, MSB first:
  - Dot = "10"; dash = "1110". Each letter ends in the inter-symbol 0.
  - Patterns and lengths: S 101010 (6); T 1110 (4); U 10101110 (8); V 1010101110 (10); W 1011101110 (10); X 111010101110 (12); Y 11101011101110 (14); Z 111011101010 (12).
  - Patterns are left-justified in the PAT_W register; unused low bits are 0.
- Start edge detect:
  - StartPrev register; start_req = Start & ~StartPrev.
  - StartPrev resets to 0.
- FSM states:
  - IDLE:
    - Busy=0, LedOut=0.
    - start_req loads the pattern for Letter into sreg and its length into remaining, then moves to SEND.
  - SEND, on Tick with remaining != 0:
    - LedOut <= sreg[PAT_W-1].
    - sreg <= sreg << 1 (zero fill).
    - remaining <= remaining - 1.
  - SEND, on Tick with remaining == 0:
    - LedOut <= 0, Done <= 1 for one cycle, go to IDLE.
  - SEND, no Tick: hold all state.
- Arithmetic:
  - remaining is unsigned LEN_W bits and never decrements below 0.
  - Shift discards the MSB.
- Boundary conditions:
  - Start edge while in SEND: ignored, not queued.
  - Letter changes during SEND: no effect.
  - Tick in the same cycle as an accepted Start in IDLE: the Tick is ignored. The first bit appears on the next Tick.
  - Tick while in IDLE: no effect.
  - Clear_b low at any time: immediate return to IDLE; sreg=0, remaining=0, LedOut=0, Busy=0, Done=0, StartPrev=0.

## Timing
- Reset values: LedOut=0, Busy=0, Done=0.
- Busy:
  - Rises the cycle after the accepted Start edge.
  - Falls together with Done, i.e. the cycle after the terminating Tick.
- LedOut:
  - Changes only one cycle after a Tick.
  - Each bit holds for exactly one Tick period.
- Duration: a pattern of N bits occupies N+1 Ticks. The final Tick yields LedOut=0 and Done.
- Done is high for exactly one ClockIn cycle per transmission.
- Worst case (Y): 15 Ticks from acceptance to Done.

## Configuration
- MORSE_REPEAT_EN defined:
  - If Start is high (level) in the cycle of the terminating Tick, Done still pulses.
  - The same latched Letter pattern reloads immediately, and the FSM stays in SEND.
  - Busy stays 1, with no IDLE cycle.
  - Start low at the terminating Tick returns to IDLE as normal.
- MORSE_REPEAT_EN undefined:
  - Always returns to IDLE after the pattern.
  - Holding Start high does nothing further; a new rising edge is required.

## Test plan
- Reset: assert Clear_b=0 mid-SEND of Y (after 5 Ticks) -> LedOut=0, Busy=0, Done=0 within the same cycle (asynchronous). After release, the FSM is in IDLE and Ticks do nothing.
- Letter=0 (S), Start pulse, Tick every 4 cycles -> LedOut sequence across Ticks 1,0,1,0,1,0,0. Done pulses once after the 7th Tick; Busy high for the whole span.
- Letter=6 (Y) -> LedOut 1,1,1,0,1,0,1,1,1,0,1,1,1,0 then 0. Done after Tick 15. Change Letter to 1 mid-transmission -> output unchanged.
- Start edge and Tick in the same cycle in IDLE, Letter=1 (T) -> the Tick is ignored; LedOut 1,1,1,0,0 on the following 5 Ticks. A second Start edge during SEND is ignored (exactly one Done).
- Without MORSE_REPEAT_EN: Letter=2 (U), Start held high -> exactly one transmission, then IDLE. Dropping and re-raising Start starts a second transmission.
- With MORSE_REPEAT_EN: Letter=1 (T), Start held high -> repeating 1,1,1,0,0 per 5 Ticks with a Done each repetition and Busy continuously 1. Drop Start -> returns to IDLE after the current pattern.

Source files
------------

// File: rtl/morse_pattern_shifter.sv
// Serialises a Morse pattern for letters S..Z onto one LED, one bit per rate-divider Tick.
// Optional MORSE_REPEAT_EN: a Start level held at the terminating Tick reloads the same letter.
module morse_pattern_shifter #(
    parameter int PAT_W = 14,
    parameter int LEN_W = 4
) (
    input  logic       ClockIn,
    input  logic       Clear_b,
    input  logic       Tick,
    input  logic       Start,
    input  logic [2:0] Letter,
    output logic       LedOut,
    output logic       Busy,
    output logic       Done
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state;
    state_t             state_next;
    logic               start_prev;
    logic               start_req;
    logic               repeat_req;
    logic               finishing;
    logic [PAT_W-1:0]   sreg;
    logic [LEN_W-1:0]   remaining;

    // Patterns are stored left-justified so the MSB is always the next bit out
    function automatic logic [PAT_W-1:0] pattern_of(input logic [2:0] l);
        logic [13:0] p;
        case (l)
            3'd0:    p = 14'b10101000000000;
            3'd1:    p = 14'b11100000000000;
            3'd2:    p = 14'b10101110000000;
            3'd3:    p = 14'b10101011100000;
            3'd4:    p = 14'b10111011100000;
            3'd5:    p = 14'b11101010111000;
            3'd6:    p = 14'b11101011101110;
            default: p = 14'b11101110101000;
        endcase
        return PAT_W'(p) << (PAT_W - 14);
    endfunction

    function automatic logic [LEN_W-1:0] length_of(input logic [2:0] l);
        case (l)
            3'd0:    return LEN_W'(6);
            3'd1:    return LEN_W'(4);
            3'd2:    return LEN_W'(8);
            3'd3:    return LEN_W'(10);
            3'd4:    return LEN_W'(10);
            3'd5:    return LEN_W'(12);
            3'd6:    return LEN_W'(14);
            default: return LEN_W'(12);
        endcase
    endfunction

    assign start_req = Start & ~start_prev;
    assign finishing = (state == SEND) && Tick && (remaining == '0);

`ifdef MORSE_REPEAT_EN
    logic [2:0] letter_q;

    assign repeat_req = Start;

    always_ff @(posedge ClockIn or negedge Clear_b) begin
        if (!Clear_b)
            letter_q <= '0;
        else if (state == IDLE && start_req)
            letter_q <= Letter;
    end
`else
    assign repeat_req = 1'b0;
`endif

    always_ff @(posedge ClockIn or negedge Clear_b) begin
        if (!Clear_b)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_req) state_next = SEND;
            SEND:    if (finishing && !repeat_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state == SEND);
    end

    // A Tick coinciding with an accepted Start is dropped because IDLE ignores Tick
    always_ff @(posedge ClockIn or negedge Clear_b) begin
        if (!Clear_b) begin
            start_prev <= 1'b0;
            sreg       <= '0;
            remaining  <= '0;
            LedOut     <= 1'b0;
            Done       <= 1'b0;
        end else begin
            start_prev <= Start;
            Done       <= 1'b0;
            case (state)
                IDLE: begin
                    LedOut <= 1'b0;
                    if (start_req) begin
                        sreg      <= pattern_of(Letter);
                        remaining <= length_of(Letter);
                    end
                end
                SEND: begin
                    if (Tick) begin
                        if (remaining != '0) begin
                            LedOut    <= sreg[PAT_W-1];
                            sreg      <= sreg << 1;
                            remaining <= remaining - 1'b1;
                        end else begin
                            LedOut <= 1'b0;
                            Done   <= 1'b1;
`ifdef MORSE_REPEAT_EN
                            if (repeat_req) begin
                                sreg      <= pattern_of(letter_q);
                                remaining <= length_of(letter_q);
                            end
`endif
                        end
                    end
                end
                default: LedOut <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_pattern_shifter.sv
// Scoreboard bench for morse_pattern_shifter: stimulus queues the expected LED/Done/Busy
// after each Tick, a monitor pops and compares on the cycle the DUT presents the result.
module tb_morse_pattern_shifter;

    logic       ClockIn;
    logic       Clear_b;
    logic       Tick;
    logic       Start;
    logic [2:0] Letter;
    logic       LedOut;
    logic       Busy;
    logic       Done;

    typedef struct packed {
        logic led;
        logic done;
        logic busy;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   passes = 0;
    int   expDones = 0;
    int   seenDones = 0;
    logic tickSampled = 1'b0;

    morse_pattern_shifter #(.PAT_W(14), .LEN_W(4)) dut (
        .ClockIn (ClockIn),
        .Clear_b (Clear_b),
        .Tick    (Tick),
        .Start   (Start),
        .Letter  (Letter),
        .LedOut  (LedOut),
        .Busy    (Busy),
        .Done    (Done)
    );

    initial ClockIn = 1'b0;
    always #5 ClockIn = ~ClockIn;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected)
            passes++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    always @(posedge ClockIn) tickSampled <= Tick;

    // Monitor: every cycle following a sampled Tick carries one scoreboard entry
    always @(negedge ClockIn) begin
        if (Done) seenDones++;
        if (tickSampled) begin
            if (expQ.size() == 0) begin
                checkOutput("scoreboardUnderflow", 1, 0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("LedOut", int'(LedOut), int'(e.led));
                checkOutput("Done",   int'(Done),   int'(e.done));
                checkOutput("Busy",   int'(Busy),   int'(e.busy));
            end
        end
    end

    task automatic applyStimulus(input logic s, input logic [2:0] l, input logic t);
        @(posedge ClockIn);
        #1;
        Start  = s;
        Letter = l;
        Tick   = t;
    endtask

    task automatic sendTick(input logic l, input logic d, input logic b);
        exp_t e;
        e = '{led: l, done: d, busy: b};
        expQ.push_back(e);
        if (d) expDones++;
        applyStimulus(Start, Letter, 1'b1);
        repeat (3) applyStimulus(Start, Letter, 1'b0);
    endtask

    task automatic sendBits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--)
            sendTick(bits[i], 1'b0, 1'b1);
    endtask

    initial begin
        Clear_b = 1'b0;
        Start   = 1'b0;
        Letter  = 3'd0;
        Tick    = 1'b0;
        repeat (3) @(posedge ClockIn);
        #1;
        checkOutput("resetLedOut", int'(LedOut), 0);
        checkOutput("resetBusy",   int'(Busy),   0);
        checkOutput("resetDone",   int'(Done),   0);
        Clear_b = 1'b1;

        // Asynchronous clear in the middle of Y
        applyStimulus(1'b1, 3'd6, 1'b0);
        applyStimulus(1'b0, 3'd6, 1'b0);
        sendBits(16'b11101, 5);
        #2;
        checkOutput("preClearLed",  int'(LedOut), 1);
        checkOutput("preClearBusy", int'(Busy),   1);
        Clear_b = 1'b0;
        #1;
        checkOutput("clearLedOut", int'(LedOut), 0);
        checkOutput("clearBusy",   int'(Busy),   0);
        checkOutput("clearDone",   int'(Done),   0);
        repeat (2) @(posedge ClockIn);
        #1;
        Clear_b = 1'b1;
        repeat (3) sendTick(1'b0, 1'b0, 1'b0);

        // Letter S
        applyStimulus(1'b1, 3'd0, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0);
        sendBits(16'b101010, 6);
        sendTick(1'b0, 1'b1, 1'b0);

        // Letter Y, Letter changed to T mid-transmission
        applyStimulus(1'b1, 3'd6, 1'b0);
        applyStimulus(1'b0, 3'd6, 1'b0);
        sendBits(16'b111, 3);
        applyStimulus(1'b0, 3'd1, 1'b0);
        sendBits(16'b01011101110, 11);
        sendTick(1'b0, 1'b1, 1'b0);

        // Start edge together with Tick in IDLE, then a second Start edge during SEND
        expQ.push_back('{led: 1'b0, done: 1'b0, busy: 1'b1});
        applyStimulus(1'b1, 3'd1, 1'b1);
        repeat (3) applyStimulus(1'b1, 3'd1, 1'b0);
        sendTick(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'd1, 1'b0);
        applyStimulus(1'b1, 3'd1, 1'b0);
        sendTick(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'd1, 1'b0);
        sendTick(1'b1, 1'b0, 1'b1);
        sendTick(1'b0, 1'b0, 1'b1);
        sendTick(1'b0, 1'b1, 1'b0);
        sendTick(1'b0, 1'b0, 1'b0);

`ifdef MORSE_REPEAT_EN
        // Letter T with Start held: repeats until Start drops
        applyStimulus(1'b1, 3'd1, 1'b0);
        sendBits(16'b1110, 4);
        sendTick(1'b0, 1'b1, 1'b1);
        sendBits(16'b1110, 4);
        sendTick(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 3'd1, 1'b0);
        sendBits(16'b1110, 4);
        sendTick(1'b0, 1'b1, 1'b0);
        sendTick(1'b0, 1'b0, 1'b0);
`else
        // Letter U with Start held: one transmission only, re-edge for another
        applyStimulus(1'b1, 3'd2, 1'b0);
        sendBits(16'b10101110, 8);
        sendTick(1'b0, 1'b1, 1'b0);
        sendTick(1'b0, 1'b0, 1'b0);
        sendTick(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd2, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b0);
        applyStimulus(1'b0, 3'd2, 1'b0);
        sendBits(16'b10101110, 8);
        sendTick(1'b0, 1'b1, 1'b0);
`endif

        repeat (4) applyStimulus(1'b0, 3'd0, 1'b0);
        checkOutput("scoreboardDrained", expQ.size(), 0);
        checkOutput("doneCount", seenDones, expDones);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
